// File: rtl/wb_pkg.sv
// Shared write-back definitions: widths, requester indices and the holding-entry record.
package wb_pkg;

  localparam int WB_AW   = 5;
  localparam int WB_DW   = 32;
  localparam int WB_NREQ = 3;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_LINK = 2;

  localparam logic [WB_AW-1:0] REG_LINK = 5'd31;

  typedef struct packed {
    logic             valid;
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

  function automatic logic entry_hit(input wb_entry_t e, input logic [WB_AW-1:0] a);
    return e.valid && (e.addr == a);
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr wins, ptr advances past it.
module wb_rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] ptr_nxt
);

  int   idx;
  logic found;

  always_comb begin
    grant   = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_nxt    = PW'((idx + 1) % N);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-bank write-port sharing: per-requester holding entries, RR drain, pending scoreboard.
// Define WB_FORWARD_EN to add q_fwd_*/q_data_* forwarding outputs.
import wb_pkg::*;

module regfile_wb_arbiter #(
  parameter int NREQ = WB_NREQ,
  parameter int AW   = WB_AW,
  parameter int DW   = WB_DW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [DW-1:0]     wr_data,
  input  logic [AW-1:0]     q_addr_a,
  input  logic [AW-1:0]     q_addr_b,
  output logic              q_busy_a,
  output logic              q_busy_b
`ifdef WB_FORWARD_EN
  ,
  output logic              q_fwd_a,
  output logic              q_fwd_b,
  output logic [DW-1:0]     q_data_a,
  output logic [DW-1:0]     q_data_b
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  wb_entry_t       ent [NREQ];
  wb_entry_t       iss;
  wb_entry_t       sel;
  logic [PW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [NREQ-1:0] occ, grant, lo_conf;
  logic [AW-1:0]   r_addr [NREQ];
  logic [DW-1:0]   r_data [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign r_addr[i] = req_addr[i*AW +: AW];
    assign r_data[i] = req_data[i*DW +: DW];
    assign occ[i]    = ent[i].valid;
  end

  assign wr_en   = iss.valid;
  assign wr_addr = iss.addr;
  assign wr_data = iss.data;

  // Pending set: occupied entries plus the write currently on the bank port.
  function automatic logic is_pending(input logic [AW-1:0] a);
    logic hit;
    hit = entry_hit(iss, a);
    for (int j = 0; j < NREQ; j++) hit = hit | entry_hit(ent[j], a);
    return hit;
  endfunction

  function automatic logic [DW-1:0] pending_data(input logic [AW-1:0] a);
    logic [DW-1:0] d;
    d = '0;
    if (entry_hit(iss, a)) d = iss.data;
    for (int j = 0; j < NREQ; j++)
      if (entry_hit(ent[j], a)) d = ent[j].data;
    return d;
  endfunction

  // Lower index wins a same-cycle collision on a register, keeping one writer per register.
  always_comb begin
    lo_conf   = '0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++)
        if (j < i && req_valid[j] && r_addr[j] == r_addr[i]) lo_conf[i] = 1'b1;
      req_ready[i] = !ent[i].valid &&
                     (r_addr[i] == '0 || (!is_pending(r_addr[i]) && !lo_conf[i]));
    end
  end

  wb_rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
    .req     (occ),
    .ptr     (rr_ptr),
    .grant   (grant),
    .ptr_nxt (rr_ptr_nxt)
  );

  always_comb begin
    sel = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant[i]) sel = ent[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) ent[i] <= '0;
      iss    <= '0;
      rr_ptr <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i])
          ent[i].valid <= 1'b0;
        else if (req_valid[i] && req_ready[i] && r_addr[i] != '0)
          ent[i] <= '{valid: 1'b1, addr: r_addr[i], data: r_data[i]};
      end
      // Address/data hold when idle; only the enable drops.
      if (|grant) iss <= sel;
      else        iss.valid <= 1'b0;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  assign q_busy_a = (q_addr_a != '0) && is_pending(q_addr_a);
  assign q_busy_b = (q_addr_b != '0) && is_pending(q_addr_b);

`ifdef WB_FORWARD_EN
  assign q_fwd_a  = q_busy_a;
  assign q_fwd_b  = q_busy_b;
  assign q_data_a = q_busy_a ? pending_data(q_addr_a) : '0;
  assign q_data_b = q_busy_b ? pending_data(q_addr_b) : '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected writes queued at accept, checked on wr_en.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [AW-1:0]     q_addr_a, q_addr_b;
  logic              q_busy_a, q_busy_b;
`ifdef WB_FORWARD_EN
  logic              q_fwd_a, q_fwd_b;
  logic [DW-1:0]     q_data_a, q_data_b;
`endif

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  regfile_wb_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .q_addr_a  (q_addr_a),
    .q_addr_b  (q_addr_b),
    .q_busy_a  (q_busy_a),
    .q_busy_b  (q_busy_b)
`ifdef WB_FORWARD_EN
    ,
    .q_fwd_a   (q_fwd_a),
    .q_fwd_b   (q_fwd_b),
    .q_data_a  (q_data_a),
    .q_data_b  (q_data_b)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_addr[i*AW +: AW]  = a;
    req_data[i*DW +: DW]  = d;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  // Any write on the bank port must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset && wr_en) begin
      if (sb.size() == 0) begin
        check("unexpected_wr", {27'd0, wr_addr}, 64'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wr_addr", wr_addr, e.a);
        check("wr_data", wr_data, e.d);
      end
    end
  end

  // All three requesters valid at once; issue order starts at 'first'.
  task automatic contend(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic [DW-1:0] db,
                         input int first, input string tag);
    logic [AW-1:0] aa [3];
    aa[0] = a0; aa[1] = a1; aa[2] = a2;
    set_req(0, 1'b1, a0, db);
    set_req(1, 1'b1, a1, db + 1);
    set_req(2, 1'b1, a2, db + 2);
    #1;
    check({tag, "_rdy"}, req_ready, 3'b111);
    for (int k = 0; k < 3; k++) push(aa[(first + k) % 3], db + DW'((first + k) % 3));
    tick;
    for (int i = 0; i < 3; i++) set_req(i, 1'b0, '0, '0);
    for (int k = 0; k < 3; k++) begin
      tick;
      check({tag, "_wen"}, wr_en, 1'b1);
      check({tag, "_order"}, wr_addr, aa[(first + k) % 3]);
    end
    tick;
    check({tag, "_idle"}, wr_en, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0; req_addr = '0; req_data = '0;
    q_addr_a = '0; q_addr_b = '0;
    tick; tick;
    reset = 1'b0;
    #1;
    check("rst_wen",   wr_en,   1'b0);
    check("rst_waddr", wr_addr, 5'd0);
    check("rst_wdata", wr_data, 32'd0);
    check("rst_rdy",   req_ready, 3'b111);

    // single uncontended write
    set_req(0, 1'b1, 5'd8, 32'hDEADBEEF);
    q_addr_a = 5'd8;
    #1;
    check("single_rdy", req_ready[0], 1'b1);
    check("single_busy_pre", q_busy_a, 1'b0);
    push(5'd8, 32'hDEADBEEF);
    tick;
    set_req(0, 1'b0, '0, '0);
    #1;
    check("single_busy_e0", q_busy_a, 1'b1);
    check("single_wen_e0", wr_en, 1'b0);
    tick;
    check("single_wen_e1", wr_en, 1'b1);
    check("single_addr_e1", wr_addr, 5'd8);
    check("single_data_e1", wr_data, 32'hDEADBEEF);
    check("single_busy_e1", q_busy_a, 1'b1);
    tick;
    check("single_busy_e2", q_busy_a, 1'b0);
    check("single_wen_e2", wr_en, 1'b0);
    check("single_hold_addr", wr_addr, 5'd8);

    // pointer sits at 1 after granting ALU
    contend(5'd12, 5'd13, 5'd14, 32'h0000_0100, 1, "rr1");

    reset = 1'b1;
    tick;
    reset = 1'b0;
    contend(5'd3, 5'd4, 5'd31, 32'h0000_0200, 0, "c3");
    contend(5'd6, 5'd7, 5'd8, 32'h0000_0300, 0, "c3again");

    // WAW: LOAD holds r5, ALU waits until it leaves issue
    set_req(1, 1'b1, 5'd5, 32'hAAAA0005);
    #1;
    check("waw_load_rdy", req_ready[1], 1'b1);
    push(5'd5, 32'hAAAA0005);
    tick;
    set_req(1, 1'b0, '0, '0);
    set_req(0, 1'b1, 5'd5, 32'hBBBB0005);
    #1;
    check("waw_blk_e0", req_ready[0], 1'b0);
    tick;
    check("waw_blk_e1", req_ready[0], 1'b0);
    check("waw_wr_e1", wr_addr, 5'd5);
    tick;
    check("waw_ok_e2", req_ready[0], 1'b1);
    push(5'd5, 32'hBBBB0005);
    tick;
    set_req(0, 1'b0, '0, '0);
    tick; tick; tick;

    // same-cycle collision on r31: ALU wins
    set_req(0, 1'b1, 5'd31, 32'hC0C0_0000);
    set_req(2, 1'b1, 5'd31, 32'hC2C2_0002);
    #1;
    check("same_alu_rdy", req_ready[0], 1'b1);
    check("same_link_rdy", req_ready[2], 1'b0);
    push(5'd31, 32'hC0C0_0000);
    tick;
    set_req(0, 1'b0, '0, '0);
    #1;
    check("same_link_e0", req_ready[2], 1'b0);
    tick;
    check("same_link_e1", req_ready[2], 1'b0);
    tick;
    check("same_link_e2", req_ready[2], 1'b1);
    push(5'd31, 32'hC2C2_0002);
    tick;
    set_req(2, 1'b0, '0, '0);
    tick; tick; tick;

    // register 0 is accepted and dropped
    q_addr_a = 5'd0;
    set_req(2, 1'b1, 5'd0, 32'h0000_1234);
    #1;
    check("r0_rdy", req_ready[2], 1'b1);
    check("r0_busy_pre", q_busy_a, 1'b0);
    tick;
    set_req(2, 1'b0, '0, '0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("r0_busy", q_busy_a, 1'b0);
      check("r0_wen", wr_en, 1'b0);
      check("r0_rdy_after", req_ready[2], 1'b1);
      tick;
    end

    // reset discards buffered writes
    q_addr_a = 5'd10;
    q_addr_b = 5'd11;
    set_req(0, 1'b1, 5'd10, 32'h1010_1010);
    set_req(1, 1'b1, 5'd11, 32'h1111_1111);
    tick;
    set_req(0, 1'b0, '0, '0);
    set_req(1, 1'b0, '0, '0);
    #1;
    check("rm_busy_a_pre", q_busy_a, 1'b1);
    check("rm_busy_b_pre", q_busy_b, 1'b1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    check("rm_wen", wr_en, 1'b0);
    check("rm_rdy", req_ready, 3'b111);
    check("rm_busy_a", q_busy_a, 1'b0);
    check("rm_busy_b", q_busy_b, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick;
      check("rm_wen_later", wr_en, 1'b0);
    end

`ifdef WB_FORWARD_EN
    q_addr_b = 5'd9;
    set_req(1, 1'b1, 5'd9, 32'hCAFE0001);
    push(5'd9, 32'hCAFE0001);
    tick;
    set_req(1, 1'b0, '0, '0);
    #1;
    check("fwd_e0", q_fwd_b, 1'b1);
    check("fwd_data_e0", q_data_b, 32'hCAFE0001);
    tick;
    check("fwd_e1", q_fwd_b, 1'b1);
    check("fwd_data_e1", q_data_b, 32'hCAFE0001);
    tick;
    check("fwd_e2", q_fwd_b, 1'b0);
    check("fwd_data_e2", q_data_b, 32'd0);
`endif

    tick; tick;
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
